// File: rtl/ccsds_123b2_out_pkg.sv
// Shared types and constants for the CCSDS-123.0-B-2 output frame packer.
//   OUT_W / IN_W   : output (link) and input (core) word widths
//   CNT_W          : width of the per-frame payload word counter
//   TRAILER_WORDS  : number of trailer beats appended per frame
//   out_pack_state_t and S_* : packer FSM encoding
//   in_word_t      : 64-bit input word viewed as upper/lower 32-bit halves
package ccsds_123b2_out_pkg;

  localparam int unsigned OUT_W         = 32;
  localparam int unsigned IN_W          = 64;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned TRAILER_WORDS = 2;

  typedef logic [2:0] out_pack_state_t;

  localparam out_pack_state_t S_EMPTY = 3'd0;
  localparam out_pack_state_t S_HI    = 3'd1;
  localparam out_pack_state_t S_LO    = 3'd2;
  localparam out_pack_state_t S_TCNT  = 3'd3;
  localparam out_pack_state_t S_TSUM  = 3'd4;

  typedef struct packed {
    logic [OUT_W-1:0] hi;
    logic [OUT_W-1:0] lo;
  } in_word_t;

  // Saturating increment of the payload word counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Checksum contribution of one input word: XOR of its two halves.
  function automatic logic [OUT_W-1:0] fold_xor(input in_word_t w);
    return w.hi ^ w.lo;
  endfunction

  // Number of output beats for a frame of 'words' input words.
  function automatic int unsigned frame_beats(input int unsigned words, input bit trailer);
    return 2 * words + (trailer ? TRAILER_WORDS : 0);
  endfunction

endpackage

// File: rtl/ccsds_123b2_out_frame_packer_if.sv
// AXI-Stream style handshake bundle used on both sides of the packer.
//   data  : payload word (width W)
//   valid : source has a word
//   ready : sink accepts the word
//   last  : final word of a frame
// master drives data/valid/last, slave drives ready.
interface ccsds_123b2_out_frame_packer_if #(
  parameter int unsigned W = 32
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/ccsds_123b2_out_frame_packer.sv
// Splits 64-bit compressed words from the CCSDS-123 core into a 32-bit
// AXI-Stream (upper half first) and optionally closes each frame with a
// two-beat trailer: payload word count, then XOR checksum of all halves.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   axis_in      : 64-bit input stream (slave)
//   axis_out     : 32-bit output stream (master), data/valid/last registered
//   frame_count  : frames fully emitted (wraps)
//   busy         : packer holds or emits data
module ccsds_123b2_out_frame_packer
  import ccsds_123b2_out_pkg::*;
#(
  parameter bit          TRAILER_EN  = 1'b1,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  ccsds_123b2_out_frame_packer_if.slave   axis_in,
  ccsds_123b2_out_frame_packer_if.master  axis_out,
  output logic [FRAME_CNT_W-1:0]          frame_count,
  output logic                            busy
);

  out_pack_state_t        state_q, state_d;
  in_word_t               buf_q, buf_d;
  logic                   buf_last_q, buf_last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0]       sum_q, sum_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   busy_q;
  logic                   run_q;
  logic                   in_ready_c;
  logic                   in_hs;
  logic                   out_hs;
  in_word_t               in_word;

  assign in_word = in_word_t'(axis_in.data);

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_last_d    = buf_last_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    in_ready_c    = 1'b0;
    out_valid_d   = 1'b0;
    out_last_d    = 1'b0;
    out_data_d    = '0;
    frame_count_d = frame_count_q;

    // run_q keeps ready low until the first edge after reset release.
    case (state_q)
      S_EMPTY: in_ready_c = run_q;
      S_LO:    in_ready_c = run_q & axis_out.ready & ~buf_last_q;
      default: in_ready_c = 1'b0;
    endcase

    in_hs  = axis_in.valid & in_ready_c;
    out_hs = out_valid_q & axis_out.ready;

    case (state_q)
      S_EMPTY: if (in_hs) state_d = S_HI;
      S_HI:    if (out_hs) state_d = S_LO;
      S_LO: begin
        if (out_hs) begin
          if (buf_last_q)  state_d = TRAILER_EN ? S_TCNT : S_EMPTY;
          else if (in_hs)  state_d = S_HI;
          else             state_d = S_EMPTY;
        end
      end
      S_TCNT:  if (out_hs) state_d = S_TSUM;
      S_TSUM:  if (out_hs) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (in_hs) begin
      buf_d      = in_word;
      buf_last_d = axis_in.last;
      cnt_d      = sat_inc(cnt_q);
      sum_d      = sum_q ^ fold_xor(in_word);
    end

    // Frame end: after the checksum beat, or after the last low half when no trailer.
    if (out_hs && ((state_q == S_TSUM) ||
                   ((state_q == S_LO) && buf_last_q && !TRAILER_EN))) begin
      cnt_d = '0;
      sum_d = '0;
    end

    // Outputs are precomputed from the next state so they leave flops directly.
    out_valid_d = (state_d != S_EMPTY);
    case (state_d)
      S_HI: out_data_d = buf_d.hi;
      S_LO: begin
        out_data_d = buf_d.lo;
        out_last_d = buf_last_d & ~TRAILER_EN;
      end
      S_TCNT: out_data_d = OUT_W'(cnt_d);
      S_TSUM: begin
        out_data_d = sum_d;
        out_last_d = 1'b1;
      end
      default: out_data_d = '0;
    endcase

    if (out_hs && out_last_q) frame_count_d = frame_count_q + FRAME_CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_EMPTY;
      buf_q         <= '0;
      buf_last_q    <= 1'b0;
      cnt_q         <= '0;
      sum_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_last_q    <= buf_last_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_count_q <= frame_count_d;
      busy_q        <= (state_d != S_EMPTY);
      run_q         <= 1'b1;
    end
  end

  assign axis_in.ready   = in_ready_c;
  assign axis_out.data   = out_data_q;
  assign axis_out.valid  = out_valid_q;
  assign axis_out.last   = out_last_q;
  assign frame_count     = frame_count_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_ccsds_123b2_out_frame_packer.sv
// Bench for the output frame packer: DUT 0 built with trailer, DUT 1 without.
// A per-cycle agent drives both DUTs from per-DUT stimulus queues and checks
// every output beat against a frame-level model queue.
`timescale 1ns/1ps
module tb_ccsds_123b2_out_frame_packer;
  import ccsds_123b2_out_pkg::*;

  localparam int NDUT = 2;
  localparam int QD   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] i_data  [NDUT];
  logic        i_valid [NDUT];
  logic        i_last  [NDUT];
  logic        i_ready [NDUT];
  logic [31:0] o_data  [NDUT];
  logic        o_valid [NDUT];
  logic        o_last  [NDUT];
  logic        o_ready [NDUT];
  logic        busy    [NDUT];
  logic [15:0] fcnt    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ccsds_123b2_out_frame_packer_if #(.W(IN_W))  in_if ();
    ccsds_123b2_out_frame_packer_if #(.W(OUT_W)) out_if ();
    assign in_if.data    = i_data[g];
    assign in_if.valid   = i_valid[g];
    assign in_if.last    = i_last[g];
    assign i_ready[g]    = in_if.ready;
    assign out_if.ready  = o_ready[g];
    assign o_data[g]     = out_if.data;
    assign o_valid[g]    = out_if.valid;
    assign o_last[g]     = out_if.last;
    ccsds_123b2_out_frame_packer #(.TRAILER_EN(g == 0), .FRAME_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .axis_in(in_if), .axis_out(out_if),
      .frame_count(fcnt[g]), .busy(busy[g]));
  end

  // Stimulus queues, expected-beat queues, directed capture buffers.
  logic [63:0] src_d [NDUT][QD];
  logic        src_l [NDUT][QD];
  int          src_wr [NDUT];
  int          src_rd [NDUT];
  logic [31:0] exp_d [NDUT][QD];
  logic        exp_l [NDUT][QD];
  int          exp_wr [NDUT];
  int          exp_rd [NDUT];
  logic [31:0] cap_d [NDUT][64];
  logic        cap_l [NDUT][64];
  int          cap_n [NDUT];
  int          frames_done [NDUT];

  logic        in_pend [NDUT];
  logic        out_pend [NDUT];
  logic        stall_prev [NDUT];
  logic [31:0] prev_d [NDUT];
  logic        prev_l [NDUT];
  logic [31:0] pend_d [NDUT];
  logic        pend_l [NDUT];

  int unsigned valid_pct = 100;
  int unsigned ready_pct = 100;
  int checks   = 0;
  int failures = 0;
  logic [63:0] fw [16];

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h @%0t", nm, k, act, req, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] d, input logic l);
    exp_d[k][exp_wr[k] % QD] = d;
    exp_l[k][exp_wr[k] % QD] = l;
    exp_wr[k]++;
  endtask

  // Frame model: halves upper first, then (trailer builds) word count and XOR of all halves.
  task automatic add_frame(input int k, input int n);
    logic [31:0] x;
    bit trailer;
    trailer = (k == 0);
    x = '0;
    for (int i = 0; i < n; i++) begin
      src_d[k][src_wr[k] % QD] = fw[i];
      src_l[k][src_wr[k] % QD] = (i == n - 1);
      src_wr[k]++;
      push_exp(k, fw[i][63:32], 1'b0);
      push_exp(k, fw[i][31:0], (i == n - 1) && !trailer);
      x = x ^ fw[i][63:32] ^ fw[i][31:0];
    end
    if (trailer) begin
      push_exp(k, 32'(n), 1'b0);
      push_exp(k, x, 1'b1);
    end
  endtask

  // Agent: drive at negedge, sample and check 1ns later.
  initial begin
    for (int k = 0; k < NDUT; k++) begin
      i_valid[k] = 1'b0; i_data[k] = '0; i_last[k] = 1'b0; o_ready[k] = 1'b0;
      in_pend[k] = 1'b0; out_pend[k] = 1'b0; stall_prev[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rst) begin
          in_pend[k] = 1'b0; out_pend[k] = 1'b0; stall_prev[k] = 1'b0;
          i_valid[k] = 1'b0; o_ready[k] = 1'b0;
        end else begin
          if (in_pend[k]) begin
            src_rd[k]++;
            i_valid[k] = 1'b0;
          end
          if (out_pend[k]) begin
            if (cap_n[k] < 64) begin
              cap_d[k][cap_n[k]] = pend_d[k];
              cap_l[k][cap_n[k]] = pend_l[k];
              cap_n[k]++;
            end
            if (exp_l[k][exp_rd[k] % QD]) frames_done[k]++;
            exp_rd[k]++;
          end
          if (!i_valid[k] && src_rd[k] != src_wr[k] && $urandom_range(99) < valid_pct) begin
            i_valid[k] = 1'b1;
            i_data[k]  = src_d[k][src_rd[k] % QD];
            i_last[k]  = src_l[k][src_rd[k] % QD];
          end
          o_ready[k] = ($urandom_range(99) < ready_pct);
        end
      end
      #1;
      if (!rst) begin
        for (int k = 0; k < NDUT; k++) begin
          if (stall_prev[k])
            check("stall_hold", k, {30'd0, o_valid[k], o_last[k], o_data[k]},
                  {30'd0, 1'b1, prev_l[k], prev_d[k]});
          if (o_valid[k]) begin
            if (exp_rd[k] == exp_wr[k])
              check("extra_beat", k, {31'd0, o_last[k], o_data[k]}, 64'hX);
            else
              check("beat", k, {31'd0, o_last[k], o_data[k]},
                    {31'd0, exp_l[k][exp_rd[k] % QD], exp_d[k][exp_rd[k] % QD]});
          end
          check("frame_count", k, 64'(fcnt[k]), 64'(frames_done[k][15:0]));
          in_pend[k]    = i_valid[k] && i_ready[k];
          out_pend[k]   = o_valid[k] && o_ready[k] && (exp_rd[k] != exp_wr[k]);
          pend_d[k]     = o_data[k];
          pend_l[k]     = o_last[k];
          stall_prev[k] = o_valid[k] && !o_ready[k];
          prev_d[k]     = o_data[k];
          prev_l[k]     = o_last[k];
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  function automatic bit drained(input int k);
    return (src_rd[k] == src_wr[k]) && (exp_rd[k] == exp_wr[k]) &&
           !in_pend[k] && !out_pend[k] && !i_valid[k];
  endfunction

  task automatic wait_drain(input int k, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (drained(k)) break;
      cyc(1);
    end
    check("drain", k, 64'(drained(k)), 64'd1);
  endtask

  task automatic wait_in_hs(input int k, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (i_valid[k] && i_ready[k]) begin
        hit = 1'b1;
        break;
      end
      cyc(1);
    end
    check("in_hs_wait", k, 64'(hit), 64'd1);
  endtask

  task automatic check_cap(input int k, input int idx, input logic [31:0] d, input logic l);
    check("cap_data", k, 64'(cap_d[k][idx]), 64'(d));
    check("cap_last", k, 64'(cap_l[k][idx]), 64'(l));
  endtask

  initial begin
    logic [31:0] lit1 [8];
    logic [31:0] lit2 [4];
    logic [31:0] lit3 [4];
    bit hit;
    int n;

    lit1 = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
             32'h9999AAAA, 32'hBBBBCCCC, 32'h00000003, 32'h2222EEEE};
    lit2 = '{32'hDEADBEEF, 32'h00000001, 32'h00000001, 32'hDEADBEEE};
    lit3 = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};

    // Reset state
    rst = 1'b1;
    cyc(3);
    for (int k = 0; k < NDUT; k++) begin
      check("rst_valid", k, 64'(o_valid[k]), 64'd0);
      check("rst_last", k, 64'(o_last[k]), 64'd0);
      check("rst_in_ready", k, 64'(i_ready[k]), 64'd0);
      check("rst_fcnt", k, 64'(fcnt[k]), 64'd0);
      check("rst_busy", k, 64'(busy[k]), 64'd0);
    end
    rst = 1'b0;
    cyc(1);
    for (int k = 0; k < NDUT; k++) check("ready_after_rst", k, 64'(i_ready[k]), 64'd1);

    // Three-word frame with trailer
    fw[0] = 64'h1111_2222_3333_4444;
    fw[1] = 64'h5555_6666_7777_8888;
    fw[2] = 64'h9999_AAAA_BBBB_CCCC;
    cap_n[0] = 0;
    add_frame(0, 3);
    wait_drain(0, 200);
    check("beats3", 0, 64'(cap_n[0]), 64'(frame_beats(3, 1'b1)));
    for (int i = 0; i < 8; i++) check_cap(0, i, lit1[i], i == 7);
    check("fcnt1", 0, 64'(fcnt[0]), 64'd1);

    // Single-word frame
    fw[0] = 64'hDEAD_BEEF_0000_0001;
    cap_n[0] = 0;
    add_frame(0, 1);
    wait_drain(0, 200);
    check("beats1", 0, 64'(cap_n[0]), 64'd4);
    for (int i = 0; i < 4; i++) check_cap(0, i, lit2[i], i == 3);
    check("fcnt2", 0, 64'(fcnt[0]), 64'd2);

    // Continuous input, no backpressure: ready alternates, output never idles
    for (int i = 0; i < 12; i++) fw[i] = {$urandom, $urandom};
    add_frame(0, 12);
    wait_in_hs(0, hit);
    for (int t = 1; t < 16; t++) begin
      cyc(1);
      check("tput_in_ready", 0, 64'(i_ready[0]), 64'(t % 2 == 0));
      check("tput_out_valid", 0, 64'(o_valid[0]), 64'd1);
    end
    wait_drain(0, 200);
    check("fcnt3", 0, 64'(fcnt[0]), 64'd3);

    // No-trailer build, two-word frame
    fw[0] = 64'h0123_4567_89AB_CDEF;
    fw[1] = 64'hFEDC_BA98_7654_3210;
    cap_n[1] = 0;
    add_frame(1, 2);
    wait_drain(1, 200);
    check("beats_nt", 1, 64'(cap_n[1]), 64'(frame_beats(2, 1'b0)));
    for (int i = 0; i < 4; i++) check_cap(1, i, lit3[i], i == 3);
    check("fcnt_nt", 1, 64'(fcnt[1]), 64'd1);

    // Reset while the low half of the first word is on the output
    for (int i = 0; i < 3; i++) fw[i] = {$urandom, $urandom};
    add_frame(0, 3);
    wait_in_hs(0, hit);
    cyc(2);
    check("in_lo_valid", 0, 64'(o_valid[0]), 64'd1);
    check("in_lo_data", 0, 64'(o_data[0]), 64'(fw[0][31:0]));
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("midrst_valid", k, 64'(o_valid[k]), 64'd0);
      check("midrst_in_ready", k, 64'(i_ready[k]), 64'd0);
      check("midrst_busy", k, 64'(busy[k]), 64'd0);
      src_rd[k] = src_wr[k];
      exp_rd[k] = exp_wr[k];
      frames_done[k] = 0;
    end
    cyc(2);
    for (int k = 0; k < NDUT; k++) check("rst_hold_in_ready", k, 64'(i_ready[k]), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Post-reset frame trailer covers only its own words
    fw[0] = 64'h0000_0001_0000_0002;
    fw[1] = 64'h0000_0004_0000_0008;
    cap_n[0] = 0;
    add_frame(0, 2);
    wait_drain(0, 200);
    check("beats_post", 0, 64'(cap_n[0]), 64'd6);
    check_cap(0, 4, 32'h0000_0002, 1'b0);
    check_cap(0, 5, 32'h0000_000F, 1'b1);
    check("fcnt_post", 0, 64'(fcnt[0]), 64'd1);

    // Random frames with 50% output backpressure on both builds
    valid_pct = 70;
    ready_pct = 50;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < NDUT; k++) begin
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) fw[i] = {$urandom, $urandom};
        add_frame(k, n);
      end
    end
    wait_drain(0, 20000);
    wait_drain(1, 20000);
    check("fcnt_rand", 0, 64'(fcnt[0]), 64'd101);
    check("fcnt_rand", 1, 64'(fcnt[1]), 64'd100);
    for (int k = 0; k < NDUT; k++) check("idle_busy", k, 64'(busy[k]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
